muldiv_sequencer: RTL and testbench

//  Sequences the shared multiply unit (mult) and divide unit (div) on behalf of the CPU control FSM.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_sequencer.sv | 143 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the MULT/DIV sequencer: the 3-bit state encoding,
//   the unit-select codes that drive u_sel, and the default wait budget.
//   No ports; imported by muldiv_sequencer and anything that decodes its state.
package muldiv_pkg;

    // Sequencer state encoding (kept as plain constants for legacy decoders)
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_REJECT = 3'd5;

    // Unit select codes carried on u_sel
    localparam logic U_MULT = 1'b0;
    localparam logic U_DIV  = 1'b1;

    // Mult needs 34 cycles in WAIT (32 steps + load + finish); 40 leaves margin
    localparam int TIMEOUT_DEFAULT = 40;
    localparam int CNT_W_DEFAULT   = 6;

endpackage

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Runs one MULT or DIV request at a time on the shared iterative multiply and
//   divide units: latches and isolates the operands, resets the selected unit,
//   starts it, waits for its stop flag (with a timeout) and commits the result
//   into the architectural HI/LO registers.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   op_valid, op_is_div   request strobe and kind (0 = MULT, 1 = DIV), taken in IDLE
//   rs_val, rt_val        operands A and B from the register file
//   busy                  high in CLR/START/WAIT; the CPU stalls on it
//   done                  pulse, HI/LO hold the new result this cycle
//   div_zero              pulse, DIV by zero rejected, HI/LO untouched
//   timeout               pulse, unit never stopped, HI/LO untouched
//   HI, LO                architectural HI/LO
//   u_rst, u_start, u_sel unit reset, unit start, unit select (0 = mult, 1 = div)
//   u_A, u_B              operands held stable for the whole operation
//   mult_stop/HI/LO       multiply unit completion flag and result
//   div_stop/HI/LO        divide unit completion flag and result (HI = rem, LO = quot)
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_is_div,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        timeout,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        u_rst,
    output logic        u_start,
    output logic        u_sel,
    output logic [31:0] u_A,
    output logic [31:0] u_B,
    input  logic        mult_stop,
    input  logic [31:0] mult_HI,
    input  logic [31:0] mult_LO,
    input  logic        div_stop,
    input  logic [31:0] div_HI,
    input  logic [31:0] div_LO
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [2:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             sel_stop;
    logic [31:0]      sel_hi;
    logic [31:0]      sel_lo;

    // Only the selected unit is listened to; the other unit's stop flag may
    // still be sticky from an earlier operation and must not end this one.
    assign sel_stop = (u_sel == U_DIV) ? div_stop : mult_stop;
    assign sel_hi   = (u_sel == U_DIV) ? div_HI   : mult_HI;
    assign sel_lo   = (u_sel == U_DIV) ? div_LO   : mult_LO;
    assign cnt_inc  = wait_cnt + CNT_W'(1);

    // Status and strobe outputs decode straight from the registered state.
    // HI/LO are loaded on the edge into COMMIT, so done marks the first cycle
    // in which the new result is visible, and busy falls on that same edge.
    assign busy     = (state == S_CLR) || (state == S_START) || (state == S_WAIT);
    assign done     = (state == S_COMMIT);
    assign div_zero = (state == S_REJECT);
    assign u_start  = (state == S_START);

    // Main sequencer. u_rst and timeout are registered alongside the state so
    // that u_rst can be high in CLR, in the IDLE cycle following a timeout and
    // straight out of reset. The unit stop flags and step counters only clear
    // on a unit reset, which is why every accepted operation passes through
    // CLR before START. Operands and the unit select are captured only on
    // accept, so the units see stable inputs from CLR through COMMIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            HI       <= '0;
            LO       <= '0;
            u_rst    <= 1'b1;
            timeout  <= 1'b0;
            u_A      <= '0;
            u_B      <= '0;
            u_sel    <= U_MULT;
            wait_cnt <= '0;
        end else begin
            u_rst   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        u_A   <= rs_val;
                        u_B   <= rt_val;
                        u_sel <= op_is_div;
                        if (op_is_div && (rt_val == '0)) begin
                            state <= S_REJECT;
                        end else begin
                            state <= S_CLR;
                            u_rst <= 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    state <= S_START;
                end
                S_START: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= cnt_inc;
                    if (sel_stop) begin
                        HI    <= sel_hi;
                        LO    <= sel_lo;
                        state <= S_COMMIT;
                    end else if (cnt_inc == CNT_LIMIT) begin
                        // Give up after TIMEOUT_CYCLES full WAIT cycles and
                        // reset the hung unit on the way back to IDLE.
                        timeout <= 1'b1;
                        u_rst   <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                end
                S_REJECT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Self-checking bench for muldiv_sequencer. Behavioural mult/div units sit on
//   the unit side; expected latency and HI/LO come from plain 64-bit arithmetic
//   and the cycle budget of each unit.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int TO       = 40;
    localparam int MULT_LAT = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_is_div;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        timeout;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        u_rst;
    logic        u_start;
    logic        u_sel;
    logic [31:0] u_A;
    logic [31:0] u_B;
    logic        mult_stop;
    logic [31:0] mult_HI;
    logic [31:0] mult_LO;
    logic        div_stop;
    logic [31:0] div_HI;
    logic [31:0] div_LO;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    int div_lat    = 10;
    bit mult_hang  = 1'b0;
    bit div_hang   = 1'b0;
    int mult_cnt;
    int div_cnt;
    bit mult_run;
    bit div_run;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .op_valid(op_valid),
        .op_is_div(op_is_div),
        .rs_val(rs_val),
        .rt_val(rt_val),
        .busy(busy),
        .done(done),
        .div_zero(div_zero),
        .timeout(timeout),
        .HI(HI),
        .LO(LO),
        .u_rst(u_rst),
        .u_start(u_start),
        .u_sel(u_sel),
        .u_A(u_A),
        .u_B(u_B),
        .mult_stop(mult_stop),
        .mult_HI(mult_HI),
        .mult_LO(mult_LO),
        .div_stop(div_stop),
        .div_HI(div_HI),
        .div_LO(div_LO)
    );

    // Signed 64-bit product split into {HI, LO}
    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // Signed division: {HI = remainder, LO = quotient}
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint q;
        longint r;
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        return {r[31:0], q[31:0]};
    endfunction

    // Cycles from the accept edge to the done/div_zero cycle
    function automatic int ref_latency(input logic is_div, input logic [31:0] b, input int dlat);
        if (is_div && b == 32'd0) return 1;
        return 3 + (is_div ? dlat : MULT_LAT);
    endfunction

    // Behavioural multiply unit: sticky stop, cleared only by its unit reset
    always @(posedge clk) begin
        if (reset || (u_rst && u_sel == U_MULT)) begin
            mult_stop <= 1'b0;
            mult_run  <= 1'b0;
            mult_cnt  <= 0;
        end else if (u_start && u_sel == U_MULT) begin
            mult_run           <= 1'b1;
            mult_cnt           <= 0;
            {mult_HI, mult_LO} <= ref_mult(u_A, u_B);
        end else if (mult_run && !mult_hang) begin
            mult_cnt <= mult_cnt + 1;
            if (mult_cnt + 1 == MULT_LAT - 1) begin
                mult_stop <= 1'b1;
                mult_run  <= 1'b0;
            end
        end
    end

    // Behavioural divide unit with a run-time configurable latency
    always @(posedge clk) begin
        if (reset || (u_rst && u_sel == U_DIV)) begin
            div_stop <= 1'b0;
            div_run  <= 1'b0;
            div_cnt  <= 0;
        end else if (u_start && u_sel == U_DIV) begin
            div_run          <= 1'b1;
            div_cnt          <= 0;
            {div_HI, div_LO} <= ref_div(u_A, u_B);
        end else if (div_run && !div_hang) begin
            div_cnt <= div_cnt + 1;
            if (div_cnt + 1 == div_lat - 1) begin
                div_stop <= 1'b1;
                div_run  <= 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and observe it until done/div_zero/timeout (bounded).
    // Returns in the cycle after the terminating pulse.
    task automatic do_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output int lat, output int busy_n,
                         output int start_n, output int done_n, output bit got_dz,
                         output bit got_to, output bit stable, output bit rst_at_end);
        lat = 0; busy_n = 0; start_n = 0; done_n = 0;
        got_dz = 0; got_to = 0; stable = 1; rst_at_end = 0;
        op_valid = 1'b1; op_is_div = is_div; rs_val = a; rt_val = b;
        tick();
        if (!hold) op_valid = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (busy) busy_n++;
            if (u_start) start_n++;
            if (done) done_n++;
            if (u_A !== a || u_B !== b || u_sel !== is_div) stable = 0;
            rs_val = $urandom;
            rt_val = $urandom;
            op_is_div = 1'($urandom_range(0, 1));
            if (done || div_zero || timeout) begin
                lat = c;
                got_dz = div_zero;
                got_to = timeout;
                rst_at_end = u_rst;
                break;
            end
            tick();
        end
        tick();
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; op_valid = 1'b0; op_is_div = 1'b0; rs_val = '0; rt_val = '0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_div_zero got %b want 0", div_zero); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %b want 0", timeout); end
        checks++; if (u_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_u_start got %b want 0", u_start); end
        checks++; if (u_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_u_rst got %b want 1", u_rst); end
        checks++; if (u_sel !== 1'b0) begin errors++; $display("[TB] FAIL reset_u_sel got %b want 0", u_sel); end
        checks++; if ({u_A, u_B} !== 64'd0) begin errors++; $display("[TB] FAIL reset_operands got %h %h want 0 0", u_A, u_B); end
        checks++; if ({HI, LO} !== 64'd0) begin errors++; $display("[TB] FAIL reset_hilo got %h %h want 0 0", HI, LO); end
        reset = 1'b0;
        tick();
        checks++; if (u_rst !== 1'b0) begin errors++; $display("[TB] FAIL idle_u_rst got %b want 0", u_rst); end
        exp_hi = '0; exp_lo = '0;
    endtask

    task automatic test_mult_basic();
        int lat, bn, sn, dn; bit dz, to, st, re;
        do_op(1'b0, 32'd7, 32'd6, 1'b0, lat, bn, sn, dn, dz, to, st, re);
        {exp_hi, exp_lo} = ref_mult(32'd7, 32'd6);
        checks++; if (lat != ref_latency(1'b0, 32'd6, div_lat)) begin errors++; $display("[TB] FAIL mult_latency got %0d want %0d", lat, ref_latency(1'b0, 32'd6, div_lat)); end
        checks++; if (bn != MULT_LAT + 2) begin errors++; $display("[TB] FAIL mult_busy_cycles got %0d want %0d", bn, MULT_LAT + 2); end
        checks++; if (dn != 1) begin errors++; $display("[TB] FAIL mult_done_count got %0d want 1", dn); end
        checks++; if (sn != 1) begin errors++; $display("[TB] FAIL mult_start_count got %0d want 1", sn); end
        checks++; if (!st) begin errors++; $display("[TB] FAIL mult_operands_stable got unstable want stable"); end
        checks++; if (HI !== 32'd0 || LO !== 32'd42) begin errors++; $display("[TB] FAIL mult_7x6 got %h %h want 0 2a", HI, LO); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mult_after got done %b busy %b want 0 0", done, busy); end
    endtask

    task automatic test_mult_negative();
        int lat, bn, sn, dn; bit dz, to, st, re;
        do_op(1'b0, 32'hFFFF_FFFD, 32'd5, 1'b0, lat, bn, sn, dn, dz, to, st, re);
        {exp_hi, exp_lo} = ref_mult(32'hFFFF_FFFD, 32'd5);
        checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFF1) begin errors++; $display("[TB] FAIL mult_neg got %h %h want ffffffff fffffff1", HI, LO); end
        do_op(1'b0, 32'd2, 32'd3, 1'b0, lat, bn, sn, dn, dz, to, st, re);
        {exp_hi, exp_lo} = ref_mult(32'd2, 32'd3);
        checks++; if (lat != MULT_LAT + 3) begin errors++; $display("[TB] FAIL mult_rearm_latency got %0d want %0d", lat, MULT_LAT + 3); end
        checks++; if (HI !== exp_hi || LO !== exp_lo) begin errors++; $display("[TB] FAIL mult_rearm got %h %h want %h %h", HI, LO, exp_hi, exp_lo); end
    endtask

    task automatic test_div_zero();
        int lat, bn, sn, dn; bit dz, to, st, re;
        do_op(1'b1, 32'd100, 32'd0, 1'b0, lat, bn, sn, dn, dz, to, st, re);
        checks++; if (lat != 1 || !dz) begin errors++; $display("[TB] FAIL divzero_pulse got lat %0d dz %b want 1 1", lat, dz); end
        checks++; if (bn != 0) begin errors++; $display("[TB] FAIL divzero_busy got %0d want 0", bn); end
        checks++; if (sn != 0) begin errors++; $display("[TB] FAIL divzero_start got %0d want 0", sn); end
        checks++; if (dn != 0) begin errors++; $display("[TB] FAIL divzero_done got %0d want 0", dn); end
        checks++; if (HI !== exp_hi || LO !== exp_lo) begin errors++; $display("[TB] FAIL divzero_hilo got %h %h want %h %h", HI, LO, exp_hi, exp_lo); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("[TB] FAIL divzero_width got %b want 0", div_zero); end
    endtask

    task automatic test_div_then_mult();
        int lat, bn, sn, dn; bit dz, to, st, re;
        logic [31:0] a, b;
        for (int i = 0; i < 4; i++) begin
            div_lat = $urandom_range(3, 25);
            a = $urandom;
            b = $urandom >> $urandom_range(0, 28);
            if (b == 0) b = 32'hFFFF_FFFF;
            do_op(1'b1, a, b, 1'b0, lat, bn, sn, dn, dz, to, st, re);
            {exp_hi, exp_lo} = ref_div(a, b);
            checks++; if (lat != ref_latency(1'b1, b, div_lat)) begin errors++; $display("[TB] FAIL div_latency got %0d want %0d", lat, ref_latency(1'b1, b, div_lat)); end
            checks++; if (HI !== exp_hi || LO !== exp_lo) begin errors++; $display("[TB] FAIL div_result got %h %h want %h %h", HI, LO, exp_hi, exp_lo); end
        end
        // div_stop is still sticky here; the MULT must not finish early on it
        a = $urandom; b = $urandom;
        do_op(1'b0, a, b, 1'b0, lat, bn, sn, dn, dz, to, st, re);
        {exp_hi, exp_lo} = ref_mult(a, b);
        checks++; if (lat != MULT_LAT + 3) begin errors++; $display("[TB] FAIL stale_div_stop latency got %0d want %0d", lat, MULT_LAT + 3); end
        checks++; if (HI !== exp_hi || LO !== exp_lo) begin errors++; $display("[TB] FAIL stale_div_stop result got %h %h want %h %h", HI, LO, exp_hi, exp_lo); end
    endtask

    task automatic test_timeout();
        int lat, bn, sn, dn; bit dz, to, st, re;
        logic [31:0] a, b;
        mult_hang = 1'b1;
        do_op(1'b0, $urandom, $urandom, 1'b0, lat, bn, sn, dn, dz, to, st, re);
        mult_hang = 1'b0;
        // TO full WAIT cycles after CLR and START, pulse in the following cycle
        checks++; if (!to || lat != TO + 3) begin errors++; $display("[TB] FAIL timeout_pulse got to %b lat %0d want 1 %0d", to, lat, TO + 3); end
        checks++; if (bn != TO + 2) begin errors++; $display("[TB] FAIL timeout_busy got %0d want %0d", bn, TO + 2); end
        checks++; if (dn != 0) begin errors++; $display("[TB] FAIL timeout_done got %0d want 0", dn); end
        checks++; if (!re) begin errors++; $display("[TB] FAIL timeout_u_rst got 0 want 1"); end
        checks++; if (HI !== exp_hi || LO !== exp_lo) begin errors++; $display("[TB] FAIL timeout_hilo got %h %h want %h %h", HI, LO, exp_hi, exp_lo); end
        checks++; if (busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_after got busy %b to %b want 0 0", busy, timeout); end
        a = $urandom; b = $urandom;
        do_op(1'b0, a, b, 1'b0, lat, bn, sn, dn, dz, to, st, re);
        {exp_hi, exp_lo} = ref_mult(a, b);
        checks++; if (lat != MULT_LAT + 3 || HI !== exp_hi || LO !== exp_lo) begin errors++; $display("[TB] FAIL timeout_recover got lat %0d %h %h want %0d %h %h", lat, HI, LO, MULT_LAT + 3, exp_hi, exp_lo); end
    endtask

    task automatic test_back_to_back();
        int lat, bn, sn, dn; bit dz, to, st, re;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        do_op(1'b0, a, b, 1'b1, lat, bn, sn, dn, dz, to, st, re);
        {exp_hi, exp_lo} = ref_mult(a, b);
        checks++; if (dn != 1 || sn != 1) begin errors++; $display("[TB] FAIL b2b_counts got done %0d start %0d want 1 1", dn, sn); end
        checks++; if (!st) begin errors++; $display("[TB] FAIL b2b_operands got unstable want stable"); end
        checks++; if (lat != MULT_LAT + 3) begin errors++; $display("[TB] FAIL b2b_latency got %0d want %0d", lat, MULT_LAT + 3); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_commit_accept got busy %b want 0", busy); end
        checks++; if (HI !== exp_hi || LO !== exp_lo) begin errors++; $display("[TB] FAIL b2b_result got %h %h want %h %h", HI, LO, exp_hi, exp_lo); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bn, sn, dn; bit dz, to, st, re;
        logic [31:0] a, b;
        op_valid = 1'b1; op_is_div = 1'b0; rs_val = 32'd11; rt_val = 32'd13;
        tick();
        op_valid = 1'b0;
        repeat (11) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_wait got busy %b want 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || u_start !== 1'b0 || u_rst !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ctrl got busy %b done %b start %b rst %b want 0 0 0 1", busy, done, u_start, u_rst); end
        checks++; if ({HI, LO} !== 64'd0 || {u_A, u_B} !== 64'd0 || u_sel !== 1'b0) begin errors++; $display("[TB] FAIL midreset_regs got %h %h %h %h %b want zeros", HI, LO, u_A, u_B, u_sel); end
        exp_hi = '0; exp_lo = '0;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_done got %b want 0", done); end
        a = $urandom; b = $urandom;
        do_op(1'b0, a, b, 1'b0, lat, bn, sn, dn, dz, to, st, re);
        {exp_hi, exp_lo} = ref_mult(a, b);
        checks++; if (lat != MULT_LAT + 3 || HI !== exp_hi || LO !== exp_lo) begin errors++; $display("[TB] FAIL midreset_recover got lat %0d %h %h want %0d %h %h", lat, HI, LO, MULT_LAT + 3, exp_hi, exp_lo); end
    endtask

    task automatic test_random();
        int lat, bn, sn, dn; bit dz, to, st, re;
        logic [31:0] a, b;
        logic is_div;
        for (int i = 0; i < 16; i++) begin
            is_div = 1'($urandom_range(0, 1));
            div_lat = $urandom_range(3, 25);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 30));
            do_op(is_div, a, b, 1'b0, lat, bn, sn, dn, dz, to, st, re);
            if (!(is_div && b == 0)) {exp_hi, exp_lo} = is_div ? ref_div(a, b) : ref_mult(a, b);
            checks++; if (lat != ref_latency(is_div, b, div_lat)) begin errors++; $display("[TB] FAIL rand_latency op %0d got %0d want %0d", i, lat, ref_latency(is_div, b, div_lat)); end
            checks++; if (dz != (is_div && b == 0) || dn != !(is_div && b == 0)) begin errors++; $display("[TB] FAIL rand_outcome op %0d got dz %b done %0d", i, dz, dn); end
            checks++; if (HI !== exp_hi || LO !== exp_lo) begin errors++; $display("[TB] FAIL rand_hilo op %0d got %h %h want %h %h", i, HI, LO, exp_hi, exp_lo); end
        end
    endtask

    // Scenarios run in order; each leaves the sequencer in IDLE
    initial begin
        test_reset();
        test_mult_basic();
        test_mult_negative();
        test_div_zero();
        test_div_then_mult();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
